// File: rtl/smc_pkg.sv
// Shared types and sizes for the six-transistor serial loader.
// Optional feature macro: SMC_CLAMP_EN (zero fields stored as 1, out_err reported).
package smc_pkg;

    localparam int NUM_TR = 6;
    localparam int DW     = 3;
    localparam int OW     = 10;
    localparam int CW     = 3;

    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_TR - 1);

    typedef struct packed {
        logic [DW-1:0] w;
        logic [DW-1:0] vgs;
        logic [DW-1:0] vds;
    } tr_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CALC,
        DONE
    } smc_state_e;

    // Replace an illegal zero field with the smallest legal value.
    function automatic logic [DW-1:0] fix_field(input logic [DW-1:0] f);
        return (f == '0) ? DW'(1) : f;
    endfunction

    function automatic tr_t clamp_tr(input tr_t t);
        tr_t r;
        r.w   = fix_field(t.w);
        r.vgs = fix_field(t.vgs);
        r.vds = fix_field(t.vds);
        return r;
    endfunction

    function automatic logic has_zero(input tr_t t);
        return (t.w == '0) || (t.vgs == '0) || (t.vds == '0);
    endfunction

endpackage

// File: rtl/smc_frame_buf.sv
// Six-entry transistor register file feeding the calculator operand ports.
// Optional feature macro: SMC_CLAMP_EN (clamps zero fields, reports zero_hit).
module smc_frame_buf
    import smc_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [CW-1:0] idx,
    input  tr_t           din,
`ifdef SMC_CLAMP_EN
    output logic          zero_hit,
`endif
    output logic [DW-1:0] W_0,
    output logic [DW-1:0] V_GS_0,
    output logic [DW-1:0] V_DS_0,
    output logic [DW-1:0] W_1,
    output logic [DW-1:0] V_GS_1,
    output logic [DW-1:0] V_DS_1,
    output logic [DW-1:0] W_2,
    output logic [DW-1:0] V_GS_2,
    output logic [DW-1:0] V_DS_2,
    output logic [DW-1:0] W_3,
    output logic [DW-1:0] V_GS_3,
    output logic [DW-1:0] V_DS_3,
    output logic [DW-1:0] W_4,
    output logic [DW-1:0] V_GS_4,
    output logic [DW-1:0] V_DS_4,
    output logic [DW-1:0] W_5,
    output logic [DW-1:0] V_GS_5,
    output logic [DW-1:0] V_DS_5
);

    tr_t [NUM_TR-1:0] ent;
    tr_t              wdata;

`ifdef SMC_CLAMP_EN
    assign wdata    = clamp_tr(din);
    assign zero_hit = has_zero(din);
`else
    assign wdata    = din;
`endif

    // Each entry changes only on the beat addressed to it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent <= '0;
        end else begin
            for (int k = 0; k < NUM_TR; k++) begin
                if (we && (idx == CW'(k))) begin
                    ent[k] <= wdata;
                end
            end
        end
    end

    assign W_0    = ent[0].w;
    assign V_GS_0 = ent[0].vgs;
    assign V_DS_0 = ent[0].vds;
    assign W_1    = ent[1].w;
    assign V_GS_1 = ent[1].vgs;
    assign V_DS_1 = ent[1].vds;
    assign W_2    = ent[2].w;
    assign V_GS_2 = ent[2].vgs;
    assign V_DS_2 = ent[2].vds;
    assign W_3    = ent[3].w;
    assign V_GS_3 = ent[3].vgs;
    assign V_DS_3 = ent[3].vds;
    assign W_4    = ent[4].w;
    assign V_GS_4 = ent[4].vgs;
    assign V_DS_4 = ent[4].vds;
    assign W_5    = ent[5].w;
    assign V_GS_5 = ent[5].vgs;
    assign V_DS_5 = ent[5].vds;

endmodule

// File: rtl/smc_serial_loader.sv
// Serial beat loader and result capture for the six-transistor calculator.
// Optional feature macro: SMC_CLAMP_EN (zero-field clamp and out_err flag).
module smc_serial_loader
    import smc_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] w_in,
    input  logic [DW-1:0] vgs_in,
    input  logic [DW-1:0] vds_in,
    input  logic [1:0]    mode_in,
    output logic [DW-1:0] W_0,
    output logic [DW-1:0] V_GS_0,
    output logic [DW-1:0] V_DS_0,
    output logic [DW-1:0] W_1,
    output logic [DW-1:0] V_GS_1,
    output logic [DW-1:0] V_DS_1,
    output logic [DW-1:0] W_2,
    output logic [DW-1:0] V_GS_2,
    output logic [DW-1:0] V_DS_2,
    output logic [DW-1:0] W_3,
    output logic [DW-1:0] V_GS_3,
    output logic [DW-1:0] V_DS_3,
    output logic [DW-1:0] W_4,
    output logic [DW-1:0] V_GS_4,
    output logic [DW-1:0] V_DS_4,
    output logic [DW-1:0] W_5,
    output logic [DW-1:0] V_GS_5,
    output logic [DW-1:0] V_DS_5,
    output logic [1:0]    mode,
    input  logic [OW-1:0] out_n,
    output logic          out_valid,
    output logic [OW-1:0] out_data,
    output logic          out_err
);

    smc_state_e    state;
    logic [CW-1:0] cnt;
    logic          accept;
    tr_t           beat;

    assign accept   = in_valid && in_ready;
    assign beat.w   = w_in;
    assign beat.vgs = vgs_in;
    assign beat.vds = vds_in;

`ifdef SMC_CLAMP_EN
    logic zero_hit;
    logic flag;
`endif

    smc_frame_buf u_buf (
        .clk      (clk),
        .rst      (rst),
        .we       (accept),
        .idx      (cnt),
        .din      (beat),
`ifdef SMC_CLAMP_EN
        .zero_hit (zero_hit),
`endif
        .W_0      (W_0),
        .V_GS_0   (V_GS_0),
        .V_DS_0   (V_DS_0),
        .W_1      (W_1),
        .V_GS_1   (V_GS_1),
        .V_DS_1   (V_DS_1),
        .W_2      (W_2),
        .V_GS_2   (V_GS_2),
        .V_DS_2   (V_DS_2),
        .W_3      (W_3),
        .V_GS_3   (V_GS_3),
        .V_DS_3   (V_DS_3),
        .W_4      (W_4),
        .V_GS_4   (V_GS_4),
        .V_DS_4   (V_DS_4),
        .W_5      (W_5),
        .V_GS_5   (V_GS_5),
        .V_DS_5   (V_DS_5)
    );

    // Frame sequencing, beat counting and result capture with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            mode      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        mode  <= mode_in;
                        cnt   <= CW'(1);
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (cnt == LAST_IDX) begin
                            cnt      <= '0;
                            in_ready <= 1'b0;
                            state    <= CALC;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                CALC: begin
                    out_data  <= out_n;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SMC_CLAMP_EN
    // Sticky zero-field flag, restarted by beat 0 and published with the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag    <= 1'b0;
            out_err <= 1'b0;
        end else begin
            if (accept) begin
                flag <= (state == IDLE) ? zero_hit : (flag | zero_hit);
            end
            if (state == CALC) begin
                out_err <= flag;
            end
        end
    end
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_smc_serial_loader.sv
// Self-checking bench: directed frames plus random frames against a beat-level model.
// Build with SMC_CLAMP_EN defined to exercise the clamp variant.
module tb_smc_serial_loader;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] w_in, vgs_in, vds_in;
    logic [1:0] mode_in;
    logic [2:0] W_0, V_GS_0, V_DS_0, W_1, V_GS_1, V_DS_1;
    logic [2:0] W_2, V_GS_2, V_DS_2, W_3, V_GS_3, V_DS_3;
    logic [2:0] W_4, V_GS_4, V_DS_4, W_5, V_GS_5, V_DS_5;
    logic [1:0] mode;
    logic [9:0] out_n;
    logic       out_valid;
    logic [9:0] out_data;
    logic       out_err;

    int checks = 0;
    int failures = 0;

    smc_serial_loader dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .w_in(w_in), .vgs_in(vgs_in), .vds_in(vds_in), .mode_in(mode_in),
        .W_0(W_0), .V_GS_0(V_GS_0), .V_DS_0(V_DS_0),
        .W_1(W_1), .V_GS_1(V_GS_1), .V_DS_1(V_DS_1),
        .W_2(W_2), .V_GS_2(V_GS_2), .V_DS_2(V_DS_2),
        .W_3(W_3), .V_GS_3(V_GS_3), .V_DS_3(V_DS_3),
        .W_4(W_4), .V_GS_4(V_GS_4), .V_DS_4(V_DS_4),
        .W_5(W_5), .V_GS_5(V_GS_5), .V_DS_5(V_DS_5),
        .mode(mode), .out_n(out_n), .out_valid(out_valid),
        .out_data(out_data), .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in calculator: order-sensitive checksum of all operands and mode.
    function automatic logic [9:0] calc(input logic [53:0] ops, input logic [1:0] md);
        int s;
        s = 0;
        for (int k = 0; k < 6; k++) s += (k + 1) * int'(ops[k*9 +: 9]);
        s = s ^ (int'(md) << 7);
        return s[9:0];
    endfunction

    logic [53:0] dut_ops;
    assign dut_ops = {W_5, V_GS_5, V_DS_5, W_4, V_GS_4, V_DS_4,
                      W_3, V_GS_3, V_DS_3, W_2, V_GS_2, V_DS_2,
                      W_1, V_GS_1, V_DS_1, W_0, V_GS_0, V_DS_0};
    assign out_n = calc(dut_ops, mode);

    // Reference model state
    logic [53:0] m_ops;
    logic [1:0]  m_mode;
    int          m_cnt;
    int          m_phase;
    logic        m_ready, m_valid, m_err, m_flag;
    logic [9:0]  m_data;

    function automatic logic [2:0] fx(input logic [2:0] f);
`ifdef SMC_CLAMP_EN
        return (f == 3'd0) ? 3'd1 : f;
`else
        return f;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ops = '0; m_mode = '0; m_cnt = 0; m_phase = 0;
        m_ready = 1'b1; m_valid = 1'b0; m_err = 1'b0; m_flag = 1'b0;
        m_data = '0;
    endtask

    task automatic tick(input logic r, input logic v, input logic [2:0] w,
                        input logic [2:0] g, input logic [2:0] d, input logic [1:0] md);
        logic hit;
        rst = r; in_valid = v; w_in = w; vgs_in = g; vds_in = d; mode_in = md;
        #1;
        if (!r) check("in_ready_pre", in_ready, m_ready);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (v && m_ready) begin
            m_ops[m_cnt*9 +: 9] = {fx(w), fx(g), fx(d)};
`ifdef SMC_CLAMP_EN
            hit = (w == 0) || (g == 0) || (d == 0);
`else
            hit = 1'b0;
`endif
            if (m_cnt == 0) begin
                m_mode = md;
                m_flag = hit;
            end else begin
                m_flag = m_flag | hit;
            end
            m_cnt++;
            if (m_cnt == 6) begin
                m_cnt = 0; m_ready = 1'b0; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_valid = 1'b1; m_data = calc(m_ops, m_mode); m_err = m_flag; m_phase = 2;
        end else if (m_phase == 2) begin
            m_valid = 1'b0; m_ready = 1'b1; m_phase = 0;
        end
        @(negedge clk);
        check("operands", dut_ops, m_ops);
        check("mode", mode, m_mode);
        check("in_ready", in_ready, m_ready);
        check("out_valid", out_valid, m_valid);
        check("out_data", out_data, m_data);
        check("out_err", out_err, m_err);
    endtask

    task automatic beat(input logic [2:0] w, input logic [2:0] g, input logic [2:0] d,
                        input logic [1:0] md);
        tick(1'b0, 1'b1, w, g, d, md);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            tick(1'b0, 1'b0, 3'($urandom), 3'($urandom), 3'($urandom), 2'($urandom));
    endtask

    task automatic fixed_frame(input logic [1:0] md, input int gap);
        for (int i = 0; i < 6; i++) begin
            beat(3'd3, 3'd3, 3'd1, md);
            if (i == 2) idle(gap);
        end
        idle(3);
    endtask

    logic [2:0] exp_w2;

    initial begin
        rst = 1'b1; in_valid = 1'b0; w_in = '0; vgs_in = '0; vds_in = '0; mode_in = '0;
        model_reset();
        tick(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 2'd0);
        tick(1'b1, 1'b1, 3'd5, 3'd5, 3'd5, 2'd3);
        idle(1);

        // Fixed frames across all modes, no gaps
        fixed_frame(2'd1, 0);
        fixed_frame(2'd0, 0);
        fixed_frame(2'd2, 0);
        fixed_frame(2'd3, 0);

        // Gap of four idle cycles mid-frame
        fixed_frame(2'd1, 4);

        // in_valid held high through CALC/DONE and into the next frame
        for (int i = 0; i < 20; i++)
            beat(3'($urandom_range(1, 7)), 3'($urandom_range(1, 7)),
                 3'($urandom_range(1, 7)), 2'($urandom));
        idle(4);

        // Reset after three beats, then a fresh frame
        for (int i = 0; i < 3; i++) beat(3'd7, 3'd6, 3'd5, 2'd2);
        tick(1'b1, 1'b1, 3'd7, 3'd7, 3'd7, 2'd3);
        check("rst_ops_zero", dut_ops, 54'd0);
        for (int i = 0; i < 6; i++) beat(3'(i + 1), 3'd2, 3'(7 - i), 2'd1);
        idle(3);

        // Zero width on beat 2, then a clean frame
        for (int i = 0; i < 6; i++) beat((i == 2) ? 3'd0 : 3'd4, 3'd2, 3'd3, 2'd3);
        idle(2);
`ifdef SMC_CLAMP_EN
        exp_w2 = 3'd1;
        check("clamp_err", out_err, 1'b1);
`else
        exp_w2 = 3'd0;
        check("clamp_err", out_err, 1'b0);
`endif
        check("clamp_w2", W_2, exp_w2);
        idle(1);
        for (int i = 0; i < 6; i++) beat(3'd2, 3'd5, 3'd6, 2'd0);
        idle(2);
        check("clean_err", out_err, 1'b0);
        idle(1);

        // Random frames with random gaps and occasional zero fields
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < 30; i++) begin
                tick(1'b0, ($urandom_range(0, 3) != 0), 3'($urandom), 3'($urandom),
                     3'($urandom), 2'($urandom));
            end
            if ($urandom_range(0, 9) == 0)
                tick(1'b1, 1'b1, 3'($urandom), 3'($urandom), 3'($urandom), 2'($urandom));
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
